load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max REQ-state cycles before abort (1..255).
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port en_ls  input  2  command from control unit: 00 none, 01 load, 10 store, 11 illegal.
REQ-007 SHALL have port addr  input  DATA_W  address register value; low ADDR_W bits used.
REQ-008 SHALL have port store_data  input  DATA_W  data to write on store.
REQ-009 SHALL have port load_data  output  DATA_W  registered result of last successful load.
REQ-010 SHALL have port ls_done  output  1  one-cycle completion pulse to control unit.
REQ-011 SHALL have port ls_err  output  1  one-cycle pulse, coincident with ls_done, on timeout abort.
REQ-012 SHALL have port mem_req  output  1  memory request, held until accepted.
REQ-013 SHALL have port mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-014 SHALL have port mem_addr  output  ADDR_W  memory address; valid while mem_req=1.
REQ-015 SHALL have port mem_wdata  output  DATA_W  write data; valid while mem_req=1.
REQ-016 SHALL have port mem_rdata  input  DATA_W  read data, sampled when mem_ready=1 on a read.
REQ-017 SHALL have port mem_ready  input  1  memory accepts/completes the request this cycle.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, DONE, HOLD; all outputs registered or decoded from state only.
REQ-019 IDLE: on en_ls=01 or 10 at a clock edge SHALL latch op, addr[ADDR_W-1:0], store_data and enter REQ.
REQ-020 IDLE: en_ls=00 or 11 SHALL remain in IDLE with no memory activity; 11 SHALL NOT raise ls_err.
REQ-021 REQ: mem_req=1, mem_we=latched op is store, mem_addr/mem_wdata=latched values, stable for the entire state.
REQ-022 REQ: inputs addr/store_data/en_ls changes SHALL NOT affect latched values or the outstanding request.
REQ-023 REQ with mem_ready=1: on load SHALL capture mem_rdata into load_data; SHALL enter DONE next cycle.
REQ-024 REQ: an 8-bit cycle counter SHALL start at 0 on entry; if counter reaches TIMEOUT-1 with mem_ready=0, SHALL enter DONE with abort flag set.
REQ-025 mem_ready=1 in the same cycle the counter reaches TIMEOUT-1 SHALL count as success, not abort.
REQ-026 DONE: ls_done=1 for exactly one cycle; ls_err=1 in that cycle only if aborted; mem_req=0; next state HOLD.
REQ-027 Aborted load SHALL leave load_data unchanged; aborted store SHALL have no further memory effect from this block.
REQ-028 HOLD: ls_done=0; SHALL return to IDLE when en_ls=00, else stay in HOLD (prevents retrigger by stale en_ls).
REQ-029 Minimum latency: en_ls sampled cycle 0, mem_req cycle 1, mem_ready in cycle 1 -> ls_done cycle 2.
REQ-030 load_data SHALL hold its value across stores, illegal commands and aborts until the next successful load.
REQ-031 mem_req SHALL be 0 in IDLE, DONE and HOLD; at most one request outstanding.

Reset
REQ-032 reset=0 at a clock edge SHALL force IDLE, load_data=0, ls_done=0, ls_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, abort flag=0.
REQ-033 Reset asserted in REQ SHALL drop mem_req on the following cycle with no ls_done pulse; reset has priority over mem_ready.
REQ-034 After reset release, first command SHALL be accepted only from IDLE per REQ-019.

Verification
REQ-035 Load: en_ls=01, addr=0x0034, mem_ready high 2 cycles after mem_req with mem_rdata=0xBEEF -> mem_addr=0x34, mem_we=0, load_data=0xBEEF, one ls_done pulse, ls_err=0.
REQ-036 Store: en_ls=10, addr=0x00A5, store_data=0x1234, mem_ready in first REQ cycle -> mem_we=1, mem_addr=0xA5, mem_wdata=0x1234, ls_done at cycle 2, load_data unchanged.
REQ-037 Timeout: load with mem_ready held 0 -> mem_req high exactly 15 cycles, then ls_done=1 and ls_err=1 same cycle, load_data unchanged.
REQ-038 Held command: en_ls=01 kept high 4 cycles after ls_done -> FSM stays HOLD, no second mem_req; en_ls=00 -> IDLE next cycle.
REQ-039 Reset mid-op: reset=0 during 3rd REQ cycle -> mem_req=0 next cycle, no ls_done, all outputs at reset values.
REQ-040 Illegal/ignored: en_ls=11 for 5 cycles -> no mem_req, no ls_done, no ls_err; subsequent en_ls=01 serviced normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: turns a one-shot load/store command from the control unit into
// a single held memory request, with timeout abort and a completion handshake.
module load_store_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        en_ls,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic              ls_done,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned     CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CMD_LOAD  = 2'b01;
  localparam logic [1:0] CMD_STORE = 2'b10;
  localparam logic [1:0] CMD_NONE  = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  load_data_q, load_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_q, abort_d;

  // Upper address bits are intentionally ignored; the memory is ADDR_W wide.
  logic unused_addr_c;
  assign unused_addr_c = ^addr;

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      load_data_q <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (en_ls == CMD_LOAD || en_ls == CMD_STORE) begin
          we_d    = (en_ls == CMD_STORE);
          addr_d  = addr[ADDR_W-1:0];
          wdata_d = store_data;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A ready on the last allowed cycle still wins over the abort.
        if (mem_ready) begin
          if (!we_q) begin
            load_data_d = mem_rdata;
          end
          abort_d = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        // Wait for the command to drop so a stale en_ls cannot retrigger.
        if (en_ls == CMD_NONE) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs come straight from registers or a decode of the state register.
  assign mem_req   = (state_q == S_REQ);
  assign ls_done   = (state_q == S_DONE);
  assign ls_err    = (state_q == S_DONE) && abort_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign load_data = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: expected transactions are queued at
// command time and retired when the DUT raises ls_done.
module tb_load_store_unit;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        en_ls;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] load_data;
  logic              ls_done;
  logic              ls_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  load_store_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .en_ls(en_ls), .addr(addr), .store_data(store_data),
    .load_data(load_data), .ls_done(ls_done), .ls_err(ls_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              err;
    logic [DATA_W-1:0] ldata;
    int                nreq;
  } exp_t;

  exp_t              exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                req_cycles = 0;
  logic              mon_en = 1'b0;
  logic [DATA_W-1:0] model_ld = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: request fields while mem_req is up, retire expectations on ls_done.
  always @(negedge clk) begin
    if (mon_en) begin
      check("err_without_done", 32'(ls_err & ~ls_done), 32'd0);
      if (mem_req) begin
        req_cycles++;
        if (exp_q.size() == 0) begin
          check("spurious_req", 32'(mem_req), 32'd0);
        end else begin
          check("mem_we", 32'(mem_we), 32'(exp_q[0].we));
          check("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
          check("mem_wdata", 32'(mem_wdata), 32'(exp_q[0].wdata));
        end
      end
      if (ls_done) begin
        check("req_in_done", 32'(mem_req), 32'd0);
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(ls_done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ls_err", 32'(ls_err), 32'(e.err));
          check("load_data", 32'(load_data), 32'(e.ldata));
          check("req_cycles", 32'(req_cycles), 32'(e.nreq));
        end
        req_cycles = 0;
      end
    end
  end

  // Issue one command from IDLE; ready arrives on REQ cycle index 'delay' (>= TIMEOUT: never).
  task automatic do_op(input logic [1:0] op, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] sd, input logic [DATA_W-1:0] rd,
                       input int delay, input int hold_cycles);
    exp_t e;
    int   done_k;
    e.we    = (op == 2'b10);
    e.addr  = a[ADDR_W-1:0];
    e.wdata = sd;
    e.err   = (delay >= int'(TIMEOUT));
    e.nreq  = e.err ? int'(TIMEOUT) : delay + 1;
    if (!e.err && op == 2'b01) model_ld = rd;
    e.ldata = model_ld;
    exp_q.push_back(e);
    en_ls = op; addr = a; store_data = sd;
    @(negedge clk);
    // Inputs wander during REQ; the latched request must not follow them.
    addr = ~a; store_data = ~sd;
    done_k = -1;
    for (int k = 0; k < int'(TIMEOUT) + 5; k++) begin
      mem_ready = (k == delay);
      mem_rdata = (k == delay) ? rd : ~rd;
      @(negedge clk);
      if (ls_done) begin
        done_k = k;
        break;
      end
    end
    mem_ready = 1'b0;
    check("done_latency", 32'(done_k), 32'(e.err ? int'(TIMEOUT) - 1 : delay));
    for (int h = 0; h < hold_cycles; h++) begin
      @(negedge clk);
      check("hold_no_req", 32'(mem_req), 32'd0);
      check("hold_no_done", 32'(ls_done), 32'd0);
    end
    en_ls = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; en_ls = 2'b00; addr = '0; store_data = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_load_data", 32'(load_data), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ls_done", 32'(ls_done), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    do_op(2'b01, 16'h0034, 16'h0000, 16'hBEEF, 2, 0);
    do_op(2'b10, 16'h00A5, 16'h1234, 16'h5555, 0, 0);
    do_op(2'b01, 16'h0042, 16'h0000, 16'hDEAD, 255, 0);
    do_op(2'b01, 16'h0010, 16'h0000, 16'hCAFE, int'(TIMEOUT) - 1, 0);
    do_op(2'b10, 16'hFF3C, 16'hA5A5, 16'h0000, int'(TIMEOUT) - 2, 0);
    do_op(2'b10, 16'h0021, 16'h7777, 16'h0000, 255, 0);
    do_op(2'b01, 16'h0055, 16'h0000, 16'h1357, 1, 4);

    // Reset in the third REQ cycle: request drops, no completion, outputs cleared.
    exp_q.push_back('{we: 1'b0, addr: 8'h77, wdata: 16'h0000, err: 1'b0, ldata: 16'h0, nreq: 0});
    en_ls = 2'b01; addr = 16'h0077; store_data = 16'h0000;
    @(negedge clk);
    en_ls = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("mid_req_active", 32'(mem_req), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_ls_done", 32'(ls_done), 32'd0);
    check("mid_rst_ls_err", 32'(ls_err), 32'd0);
    check("mid_rst_load_data", 32'(load_data), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
    exp_q.delete();
    req_cycles = 0;
    model_ld = '0;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_no_done", 32'(ls_done), 32'd0);

    // Illegal command is ignored silently.
    en_ls = 2'b11; addr = 16'h0099;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("illegal_no_req", 32'(mem_req), 32'd0);
      check("illegal_no_err", 32'(ls_err), 32'd0);
      check("illegal_no_done", 32'(ls_done), 32'd0);
    end
    en_ls = 2'b00;
    @(negedge clk);
    do_op(2'b01, 16'h0099, 16'h0000, 16'h2468, 0, 0);

    for (int i = 0; i < 8; i++) begin
      do_op($urandom_range(0, 1) ? 2'b01 : 2'b10, 16'($urandom), 16'($urandom),
            16'($urandom), int'($urandom_range(0, TIMEOUT + 1)), int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
